pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 136 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Reset sequencer downstream of the PLL: holds rst_out until lock has been stable,
// re-asserts it on lock loss, counts RUN-time lock losses and strobes a microsecond tick.
module pll_reset_sequencer #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter int TICK_DIV           = 96,
   parameter int CNT_W              = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       locked,
   output logic       rst_out,
   output logic       ready,
   output logic       tick_us,
   output logic [7:0] lock_loss_cnt
);

   localparam logic [1:0] S_WAIT_LOCK = 2'd0;
   localparam logic [1:0] S_STABLE    = 2'd1;
   localparam logic [1:0] S_HOLD      = 2'd2;
   localparam logic [1:0] S_RUN       = 2'd3;

   localparam int DIV_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);

   logic [1:0]       r_sync;
   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_div;
   logic             r_rst_out;
   logic             r_ready;
   logic             r_tick;
   logic [7:0]       r_loss_cnt;

   logic             w_locked_s;
   logic [1:0]       w_state_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic [DIV_W-1:0] w_div_next;
   logic             w_rst_next;
   logic             w_ready_next;
   logic             w_tick_next;
   logic [7:0]       w_loss_next;

   assign w_locked_s = r_sync[1];

   // Outputs default to the "held in reset" values; only HOLD->RUN and RUN release them.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_div_next   = '0;
      w_rst_next   = 1'b1;
      w_ready_next = 1'b0;
      w_tick_next  = 1'b0;
      w_loss_next  = r_loss_cnt;
      case (r_state)
         S_WAIT_LOCK: begin
            w_cnt_next = '0;
            if (w_locked_s) begin
               w_state_next = S_STABLE;
            end
         end
         S_STABLE: begin
            if (!w_locked_s) begin
               w_state_next = S_WAIT_LOCK;
               w_cnt_next   = '0;
            end else if (r_cnt == STABLE_LAST) begin
               w_state_next = S_HOLD;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         S_HOLD: begin
            if (!w_locked_s) begin
               w_state_next = S_WAIT_LOCK;
               w_cnt_next   = '0;
            end else if (r_cnt == HOLD_LAST) begin
               w_state_next = S_RUN;
               w_cnt_next   = '0;
               w_rst_next   = 1'b0;
               w_ready_next = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         S_RUN: begin
            if (!w_locked_s) begin
               w_state_next = S_WAIT_LOCK;
               w_cnt_next   = '0;
               if (r_loss_cnt != 8'hFF) begin
                  w_loss_next = r_loss_cnt + 8'd1;
               end
            end else begin
               w_rst_next   = 1'b0;
               w_ready_next = 1'b1;
               w_tick_next  = (r_div == DIV_LAST);
               w_div_next   = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            end
         end
         default: begin
            w_state_next = S_WAIT_LOCK;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync     <= 2'b00;
         r_state    <= S_WAIT_LOCK;
         r_cnt      <= '0;
         r_div      <= '0;
         r_rst_out  <= 1'b1;
         r_ready    <= 1'b0;
         r_tick     <= 1'b0;
         r_loss_cnt <= 8'd0;
      end else begin
         r_sync     <= {r_sync[0], locked};
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_div      <= w_div_next;
         r_rst_out  <= w_rst_next;
         r_ready    <= w_ready_next;
         r_tick     <= w_tick_next;
         r_loss_cnt <= w_loss_next;
      end
   end

   assign rst_out       = r_rst_out;
   assign ready         = r_ready;
   assign tick_us       = r_tick;
   assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a small-parameter instance under directed and random
// lock patterns plus a default-parameter instance, both tracked by a run-length model.
module tb_pll_reset_sequencer;

   localparam int P_L [2] = '{8, 1024};
   localparam int P_H [2] = '{4, 16};
   localparam int P_T [2] = '{5, 96};

   localparam int SIG_READY = 0;
   localparam int SIG_RST   = 1;
   localparam int SIG_TICK  = 2;

   logic       clk;
   logic       reset, locked;
   logic       rst_out, ready, tick_us;
   logic [7:0] lock_loss_cnt;
   logic       reset_d, locked_d;
   logic       rst_out_d, ready_d, tick_us_d;
   logic [7:0] lock_loss_cnt_d;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   bit  done_d  = 0;

   pll_reset_sequencer #(
      .LOCK_STABLE_CYCLES(8),
      .RESET_HOLD_CYCLES (4),
      .TICK_DIV          (5),
      .CNT_W             (16)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .locked       (locked),
      .rst_out      (rst_out),
      .ready        (ready),
      .tick_us      (tick_us),
      .lock_loss_cnt(lock_loss_cnt)
   );

   pll_reset_sequencer u_dut_def (
      .clk          (clk),
      .reset        (reset_d),
      .locked       (locked_d),
      .rst_out      (rst_out_d),
      .ready        (ready_d),
      .tick_us      (tick_us_d),
      .lock_loss_cnt(lock_loss_cnt_d)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic get_sig(input int inst, input int which);
      logic v;
      v = 1'b0;
      case (which)
         SIG_READY: v = (inst == 0) ? ready   : ready_d;
         SIG_RST:   v = (inst == 0) ? rst_out : rst_out_d;
         default:   v = (inst == 0) ? tick_us : tick_us_d;
      endcase
      return v;
   endfunction

   // Waits (sampling on negedges) until a DUT output takes a value; timeout counts as a failure.
   task automatic wait_sig(input int inst, input int which, input logic val, input int max_cyc,
                           input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (get_sig(inst, which) === val) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: timeout after %0d cycles, signal never reached %0b", name, max_cyc, val);
      end
   endtask

   // Model: count consecutive edges at which the synchronized lock was seen high.
   // Release happens when that run reaches 1+L+H; ticks every T edges thereafter.
   int run_len [2];
   int m_s1    [2];
   int m_s2    [2];
   int m_cnt   [2];
   bit m_valid [2];

   initial begin
      logic rin [2];
      logic lin [2];
      int   ls, rel, m;
      bit   er, et;
      for (int i = 0; i < 2; i++) begin
         run_len[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_cnt[i] = 0; m_valid[i] = 0;
      end
      forever begin
         @(posedge clk);
         cyc++;
         rin[0] = reset;  rin[1] = reset_d;
         lin[0] = locked; lin[1] = locked_d;
         for (int i = 0; i < 2; i++) begin
            if (rin[i] === 1'b1) begin
               run_len[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_cnt[i] = 0; m_valid[i] = 1;
            end else if (m_valid[i]) begin
               ls      = m_s2[i];
               m_s2[i] = m_s1[i];
               m_s1[i] = (lin[i] === 1'b1) ? 1 : 0;
               if (ls != 0) begin
                  if (run_len[i] < 1000000) run_len[i]++;
               end else begin
                  if (run_len[i] >= 1 + P_L[i] + P_H[i] && m_cnt[i] < 255) m_cnt[i]++;
                  run_len[i] = 0;
               end
            end
         end
         #1;
         for (int i = 0; i < 2; i++) begin
            if (m_valid[i]) begin
               rel = 1 + P_L[i] + P_H[i];
               er  = (run_len[i] >= rel);
               m   = run_len[i] - rel;
               et  = er && (m > 0) && (m % P_T[i] == 0);
               check($sformatf("model%0d_ready", i), int'(get_sig(i, SIG_READY)), int'(er));
               check($sformatf("model%0d_rst_out", i), int'(get_sig(i, SIG_RST)), int'(!er));
               check($sformatf("model%0d_tick_us", i), int'(get_sig(i, SIG_TICK)), int'(et));
               check($sformatf("model%0d_loss_cnt", i),
                     int'((i == 0) ? lock_loss_cnt : lock_loss_cnt_d), m_cnt[i]);
            end
         end
      end
   end

   // Default-parameter instance: release latency and tick period.
   initial begin
      int kd;
      bit ok;
      reset_d  = 1'b1;
      locked_d = 1'b0;
      repeat (3) @(negedge clk);
      reset_d = 1'b0;
      repeat (10) @(negedge clk);
      locked_d = 1'b1;
      kd = cyc + 1;
      wait_sig(1, SIG_READY, 1'b1, 1100, "def_release", ok);
      if (ok) check("def_release_latency", cyc - kd, 1042);
      wait_sig(1, SIG_TICK, 1'b1, 200, "def_tick1", ok);
      if (ok) check("def_first_tick", cyc - kd, 1042 + 96);
      wait_sig(1, SIG_TICK, 1'b1, 200, "def_tick2", ok);
      if (ok) check("def_second_tick", cyc - kd, 1042 + 192);
      check("def_loss_before", int'(lock_loss_cnt_d), 0);
      locked_d = 1'b0;
      wait_sig(1, SIG_RST, 1'b1, 10, "def_loss", ok);
      check("def_loss_after", int'(lock_loss_cnt_d), 1);
      done_d = 1'b1;
   end

   initial begin
      int k, d, bad, left;
      bit ok;
      reset  = 1'b1;
      locked = 1'b0;

      // Power-up
      repeat (3) @(negedge clk);
      check("por_rst_out", int'(rst_out), 1);
      check("por_ready", int'(ready), 0);
      check("por_tick", int'(tick_us), 0);
      check("por_loss_cnt", int'(lock_loss_cnt), 0);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rst_out !== 1'b1 || ready !== 1'b0 || tick_us !== 1'b0) bad++;
      end
      check("por_held_50", bad, 0);

      // Clean lock
      locked = 1'b1;
      k = cyc + 1;
      wait_sig(0, SIG_READY, 1'b1, 40, "clean_release", ok);
      if (ok) check("clean_release_edge", cyc - k, 14);
      check("clean_rst_low", int'(rst_out), 0);
      wait_sig(0, SIG_TICK, 1'b1, 20, "clean_tick1", ok);
      if (ok) check("clean_first_tick", cyc - k, 19);
      wait_sig(0, SIG_TICK, 1'b1, 20, "clean_tick2", ok);
      if (ok) check("clean_second_tick", cyc - k, 24);

      // Unstable lock
      reset  = 1'b1;
      locked = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      locked = 1'b1;
      repeat (5) @(negedge clk);
      locked = 1'b0;
      repeat (2) @(negedge clk);
      locked = 1'b1;
      k = cyc + 1;
      wait_sig(0, SIG_READY, 1'b1, 40, "unstable_release", ok);
      if (ok) check("unstable_release_edge", cyc - k, 14);
      check("unstable_loss_cnt", int'(lock_loss_cnt), 0);

      // Lock loss in RUN
      repeat (7) @(negedge clk);
      locked = 1'b0;
      d = cyc + 1;
      wait_sig(0, SIG_RST, 1'b1, 10, "runloss_rst", ok);
      if (ok) check("runloss_rst_edge", cyc - d, 2);
      check("runloss_cnt", int'(lock_loss_cnt), 1);
      check("runloss_tick_off", int'(tick_us), 0);
      locked = 1'b1;
      k = cyc + 1;
      wait_sig(0, SIG_READY, 1'b1, 40, "runloss_rerelease", ok);
      if (ok) check("runloss_rerelease_edge", cyc - k, 14);
      check("runloss_cnt_kept", int'(lock_loss_cnt), 1);

      // Saturation
      for (int i = 0; i < 260; i++) begin
         wait_sig(0, SIG_READY, 1'b1, 40, "sat_run", ok);
         if (!ok) break;
         locked = 1'b0;
         repeat (3) @(negedge clk);
         locked = 1'b1;
      end
      wait_sig(0, SIG_READY, 1'b1, 40, "sat_final_run", ok);
      check("sat_cnt_255", int'(lock_loss_cnt), 255);
      locked = 1'b0;
      repeat (3) @(negedge clk);
      locked = 1'b1;
      wait_sig(0, SIG_READY, 1'b1, 40, "sat_again_run", ok);
      check("sat_cnt_stays", int'(lock_loss_cnt), 255);

      // Reset during the second HOLD cycle
      reset  = 1'b1;
      locked = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      locked = 1'b1;
      k = cyc + 1;
      repeat (12) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midhold_rst_out", int'(rst_out), 1);
      check("midhold_ready", int'(ready), 0);
      check("midhold_loss_clear", int'(lock_loss_cnt), 0);
      reset = 1'b0;
      k = cyc + 1;
      wait_sig(0, SIG_READY, 1'b1, 40, "midhold_release", ok);
      if (ok) check("midhold_release_edge", cyc - k, 14);

      // Random lock patterns with occasional reset, checked by the model every cycle
      left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (left == 0) begin
            locked = ~locked;
            left   = locked ? $urandom_range(1, 40) : $urandom_range(1, 6);
         end
         left--;
         reset = ($urandom_range(0, 199) == 0);
         @(negedge clk);
      end
      reset = 1'b0;

      for (int i = 0; i < 3000 && !done_d; i++) @(negedge clk);
      check("default_thread_done", int'(done_d), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
